// File: rtl/udp_pkg.sv
// Shared constants and state encoding for the UDP receive path.
package udp_pkg;
  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL       = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
  localparam logic [15:0] UDP_HDR_OVERHEAD = 16'd10;
  localparam logic [3:0]  HDR_LAST_IDX     = 4'd10;
  localparam int          FLAG_SOF         = 0;
  localparam int          FLAG_EOF         = 1;
  localparam logic [9:0]  MAX_PL_WORDS     = 10'd512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;
endpackage

// File: rtl/ip_csum_verify.sv
// 16-bit ones'-complement accumulator over up to two halfwords per cycle.
module ip_csum_verify (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] hw_a_i,
  input  logic [15:0] hw_b_i,
  output logic        ok_o
);
  logic [15:0] acc_q, acc_d;
  logic [17:0] sum;
  logic [16:0] fold1;

  // Two folds suffice: after the first the value is at most 0x10001.
  always_comb begin
    sum   = {2'b00, acc_q} + {2'b00, hw_a_i} + {2'b00, hw_b_i};
    fold1 = {1'b0, sum[15:0]} + {15'd0, sum[17:16]};
    acc_d = fold1[15:0] + {15'd0, fold1[16]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   acc_q <= 16'h0000;
    else if (clr_i) acc_q <= 16'h0000;
    else if (en_i)  acc_q <= acc_d;
  end

  assign ok_o = (acc_q == 16'hffff);
endmodule

// File: rtl/udp_packet_receiver.sv
// Ethernet/IPv4/UDP frame receiver: header filter, payload writer, per-frame status.
// Optional IP header checksum verification when RX_IPCSUM_CHECK_EN is defined.
module udp_packet_receiver
  import udp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h0037_ffff_3737,
  parameter logic [31:0] LOCAL_IP   = 32'ha9fe_4d01,
  parameter logic [15:0] LOCAL_PORT = 16'h1234
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  rd_flags_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_src_rdy_i,
  output logic        rd_dst_rdy_o,
  output logic [31:0] pl_fifo_d,
  output logic        pl_fifo_wr,
  input  logic        pl_fifo_full,
  output logic        pkt_done_o,
  output logic        pkt_err_o,
  output logic        pkt_drop_o,
  output logic [8:0]  pkt_size_o,
  output logic [31:0] pkt_src_ip_o,
  output logic [15:0] pkt_src_port_o
);
  rx_state_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        mac_loc_q, mac_loc_d, mac_bc_q, mac_bc_d;
  logic        sup_drop_q, sup_drop_d;
  logic [15:0] sip_hi_q, sip_hi_d, sip_lo_q, sip_lo_d;
  logic [15:0] sport_q, sport_d, udp_len_q, udp_len_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic        wr_q, wr_d, done_q, done_d, err_q, err_d, drop_q, drop_d;
  logic [31:0] dat_q, dat_d;
  logic [8:0]  size_q, size_d;
  logic        accept, sof, eof, csum_ok, hdr_ok;
  logic [9:0]  cnt_p1, cnt_m1;
  logic [15:0] exp_words;
  logic        unused_flags;

  function automatic logic hdr_word_ok(input logic [3:0] idx, input logic [31:0] w,
                                       input logic loc, input logic bc);
    case (idx)
      4'd1:    return (loc && (w[31:16] == LOCAL_MAC[15:0])) || (bc && (w[31:16] == 16'hffff));
      4'd3:    return (w[31:16] == ETHERTYPE_IPV4) && (w[15:8] == IP_VER_IHL);
      4'd5:    return (w[7:0] == IP_PROTO_UDP);
      4'd7:    return (w[15:0] == LOCAL_IP[31:16]);
      4'd8:    return (w[31:16] == LOCAL_IP[15:0]);
      4'd9:    return (w[31:16] == LOCAL_PORT);
      default: return 1'b1;
    endcase
  endfunction

  assign rd_dst_rdy_o = !((state_q == ST_PAYLOAD) && pl_fifo_full);
  assign accept       = rd_src_rdy_i && rd_dst_rdy_o;
  assign sof          = rd_flags_i[FLAG_SOF];
  assign eof          = rd_flags_i[FLAG_EOF];
  assign unused_flags = ^rd_flags_i[3:2];
  assign cnt_p1       = cnt_q + 10'd1;
  assign cnt_m1       = cnt_q - 10'd1;
  assign exp_words    = ((udp_len_q - UDP_HDR_OVERHEAD) >> 2) + 16'd1;

`ifdef RX_IPCSUM_CHECK_EN
  logic        csum_clr, csum_en;
  logic [15:0] csum_a, csum_b;

  // w3 and w8 contribute one halfword each, w4..w7 contribute both.
  always_comb begin
    csum_clr = accept && sof;
    csum_en  = accept && !sof && (state_q == ST_HDR) && (idx_q >= 4'd3) && (idx_q <= 4'd8);
    csum_a   = rd_data_i[31:16];
    csum_b   = rd_data_i[15:0];
    if (idx_q == 4'd3) begin
      csum_a = rd_data_i[15:0];
      csum_b = 16'h0000;
    end else if (idx_q == 4'd8) begin
      csum_b = 16'h0000;
    end
  end

  ip_csum_verify u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (csum_clr),
    .en_i    (csum_en),
    .hw_a_i  (csum_a),
    .hw_b_i  (csum_b),
    .ok_o    (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  assign hdr_ok = hdr_word_ok(idx_q, rd_data_i, mac_loc_q, mac_bc_q) &&
                  ((idx_q != 4'd9) || csum_ok);

  always_comb begin
    state_d    = state_q;    idx_d      = idx_q;      cnt_d     = cnt_q;
    mac_loc_d  = mac_loc_q;  mac_bc_d   = mac_bc_q;   sup_drop_d = sup_drop_q;
    sip_hi_d   = sip_hi_q;   sip_lo_d   = sip_lo_q;   sport_d   = sport_q;
    udp_len_d  = udp_len_q;  src_ip_d   = src_ip_q;   src_port_d = src_port_q;
    dat_d      = dat_q;      size_d     = size_q;
    wr_d = 1'b0; done_d = 1'b0; err_d = 1'b0; drop_d = 1'b0;
    if (accept && sof) begin
      // An SOF always restarts parsing; any frame in flight is aborted first.
      case (state_q)
        ST_PAYLOAD: begin err_d = 1'b1; size_d = cnt_m1[8:0]; end
        ST_HDR:     drop_d = 1'b1;
        ST_DROP:    drop_d = !sup_drop_q;
        default:    ;
      endcase
      mac_loc_d  = (rd_data_i == LOCAL_MAC[47:16]);
      mac_bc_d   = (rd_data_i == 32'hffff_ffff);
      sup_drop_d = 1'b0;
      idx_d      = 4'd1;
      if (eof) begin
        drop_d  = 1'b1;
        state_d = ST_IDLE;
      end else if (!(mac_loc_d || mac_bc_d)) state_d = ST_DROP;
      else                                   state_d = ST_HDR;
    end else if (accept) begin
      case (state_q)
        ST_HDR: begin
          idx_d = idx_q + 4'd1;
          case (idx_q)
            4'd6: sip_hi_d = rd_data_i[15:0];
            4'd7: sip_lo_d = rd_data_i[31:16];
            4'd8: sport_d  = rd_data_i[15:0];
            4'd9: begin
              udp_len_d = rd_data_i[15:0];
              if (hdr_ok) begin
                src_ip_d   = {sip_hi_q, sip_lo_q};
                src_port_d = sport_q;
              end
            end
            default: ;
          endcase
          if (eof) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (!hdr_ok) state_d = ST_DROP;
          else if (idx_q == HDR_LAST_IDX) begin
            state_d = ST_PAYLOAD;
            cnt_d   = 10'd0;
          end
        end
        ST_PAYLOAD: begin
          if (cnt_q == MAX_PL_WORDS) begin
            // Overlong frame: report once as an error, then swallow the rest silently.
            err_d      = 1'b1;
            size_d     = 9'd511;
            sup_drop_d = 1'b1;
            state_d    = eof ? ST_IDLE : ST_DROP;
          end else begin
            wr_d  = 1'b1;
            dat_d = rd_data_i;
            cnt_d = cnt_p1;
            if (eof) begin
              size_d  = cnt_q[8:0];
              done_d  = ({6'd0, cnt_p1} == exp_words);
              err_d   = ({6'd0, cnt_p1} != exp_words);
              state_d = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (eof) begin
            drop_d  = !sup_drop_q;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;  idx_q    <= 4'd0;   cnt_q      <= 10'd0;
      mac_loc_q <= 1'b0;     mac_bc_q <= 1'b0;   sup_drop_q <= 1'b0;
      sip_hi_q  <= 16'd0;    sip_lo_q <= 16'd0;  sport_q    <= 16'd0;
      udp_len_q <= 16'd0;    src_ip_q <= 32'd0;  src_port_q <= 16'd0;
      wr_q      <= 1'b0;     dat_q    <= 32'd0;  size_q     <= 9'd0;
      done_q    <= 1'b0;     err_q    <= 1'b0;   drop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;   idx_q    <= idx_d;    cnt_q      <= cnt_d;
      mac_loc_q <= mac_loc_d; mac_bc_q <= mac_bc_d; sup_drop_q <= sup_drop_d;
      sip_hi_q  <= sip_hi_d;  sip_lo_q <= sip_lo_d; sport_q    <= sport_d;
      udp_len_q <= udp_len_d; src_ip_q <= src_ip_d; src_port_q <= src_port_d;
      wr_q      <= wr_d;      dat_q    <= dat_d;    size_q     <= size_d;
      done_q    <= done_d;    err_q    <= err_d;    drop_q     <= drop_d;
    end
  end

  assign pl_fifo_d      = dat_q;
  assign pl_fifo_wr     = wr_q;
  assign pkt_done_o     = done_q;
  assign pkt_err_o      = err_q;
  assign pkt_drop_o     = drop_q;
  assign pkt_size_o     = size_q;
  assign pkt_src_ip_o   = src_ip_q;
  assign pkt_src_port_o = src_port_q;
endmodule
